vtg_pattern_gen: RTL and testbench
==================================

VTG_PATTERN_GEN -- requirements
Module: vtg_pattern_gen

Interface
REQ-001 SHALL have parameter H_BPORCH, default 40, horizontal back porch in pixels.
REQ-002 SHALL have parameter H_ACTIVE, default 2560, active pixels per line.
REQ-003 SHALL have parameter H_FPORCH, default 8, horizontal front porch.
REQ-004 SHALL have parameter H_SYNC, default 32, hsync width.
REQ-005 SHALL have parameter H_POLAR, default 1, hsync asserted level.
REQ-006 SHALL have parameters V_BPORCH 6, V_ACTIVE 1440, V_FPORCH 13, V_SYNC 8, V_POLAR 0 (vertical equivalents, in lines).
REQ-007 SHALL have parameter CNT_W, default 12, width of the h/v counters.
REQ-008 SHALL have parameter CHECK_LOG2, default 5, checkerboard square edge = 2^CHECK_LOG2 pixels.
REQ-009 Ports: clk_pixel in 1 pixel clock; rst_n in 1 asynchronous active-low reset.
REQ-010 Ports: en in 1 run enable (PLL lock); mode in 2 pattern select; solid_rgb in 24 solid colour {R,G,B}.
REQ-011 Ports: rgb_hs, rgb_vs, rgb_de out 1 each; rgb_r, rgb_g, rgb_b out 8 each.
REQ-012 Ports: pos_x, pos_y out CNT_W active-area coordinates; sof out 1 start-of-frame pulse.

Function
REQ-013 Line order SHALL be back porch, active, front porch, sync; h_total = sum of the four H parameters; v_total likewise.
REQ-014 cnt_h SHALL increment each cycle with en=1, wrapping at h_total-1 to 0; cnt_v SHALL increment on each h wrap, wrapping at v_total-1.
REQ-015 With en=0, cnt_h and cnt_v SHALL be held at 0 synchronously and outputs SHALL take their reset values.
REQ-016 hs SHALL be H_POLAR when cnt_h >= H_BPORCH+H_ACTIVE+H_FPORCH, else ~H_POLAR; vs likewise on cnt_v.
REQ-017 de SHALL be 1 iff H_BPORCH <= cnt_h < H_BPORCH+H_ACTIVE and V_BPORCH <= cnt_v < V_BPORCH+V_ACTIVE.
REQ-018 All outputs SHALL be registered with exactly one clk_pixel latency from the counters; hs, vs, de, rgb, pos_x, pos_y SHALL remain mutually aligned.
REQ-019 pos_x = cnt_h-H_BPORCH and pos_y = cnt_v-V_BPORCH while de=1; both SHALL be 0 while de=0.
REQ-020 sof SHALL pulse for one cycle, aligned with the output for cnt_h=0, cnt_v=0.
REQ-021 mode SHALL be sampled only at cnt_h=0, cnt_v=0; a mid-frame change SHALL take effect next frame.
REQ-022 rgb SHALL be 0 whenever de=0, regardless of mode.
REQ-023 mode 0 (SOLID): rgb = solid_rgb, sampled per pixel.
REQ-024 mode 1 (BARS): 8 bars of width H_ACTIVE/8 in order white, yellow, cyan, green, magenta, red, blue, black; remainder pixels SHALL stay black (index saturates at 7); bars SHALL be computed without a divider.
REQ-025 mode 2 (CHECKER): white when pos_x[CHECK_LOG2] XOR pos_y[CHECK_LOG2] = 0, else black.
REQ-026 mode 3 (FILL): a 24-bit active-pixel index counts de cycles, cleared while vs is asserted; a fill threshold increments once per frame at sof, wrapping H_ACTIVE*V_ACTIVE-1 to 0; pixel is white iff index < threshold.
REQ-027 Counter widths SHALL be checked at elaboration: h_total and v_total SHALL fit in CNT_W, else elaboration error.

Reset
REQ-028 During rst_n=0: counters 0, fill threshold 0, latched mode 0, rgb 0, de 0, sof 0, pos 0, hs = ~H_POLAR, vs = ~V_POLAR.
REQ-029 Reset assertion mid-frame SHALL take effect immediately (asynchronous); release SHALL restart at cnt_h=0, cnt_v=0 on the first enabled edge.

Structure
REQ-030 Package vtg_pkg SHALL hold the mode enum (SOLID, BARS, CHECKER, FILL) and the 8-entry bar colour table.
REQ-031 Sub-module vtg_counter SHALL implement REQ-013 to REQ-017, outputting raw cnt_h, cnt_v, hs, vs, de; pattern logic SHALL stay in vtg_pattern_gen.

Verification (small config: H 2/8/1/2 total 13, V 1/4/1/1 total 7, CHECK_LOG2=1)
REQ-032 Reset release with en=1 -> hs high for outputs of cnt_h 11-12, de high for cnt_h 2-9 on lines 1-4, sof once per 91 cycles.
REQ-033 mode=1 -> active line reads 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000.
REQ-034 mode=2 -> line 0 reads W,W,B,B,W,W,B,B; line 2 reads B,B,W,W,B,B,W,W.
REQ-035 mode=3 over 33 frames -> white-pixel count per frame 0,1,...,31, then 0 in frame 33.
REQ-036 mode changed 0 to 1 mid-frame and en dropped for 5 cycles -> change seen only after next sof; en low forces rgb 0, de 0, counters restart at 0.

Source files
------------

// File: rtl/vtg_pkg.sv
// -----------------------------------------------------------------------------
// vtg_pkg
// Shared types and constants for the video timing / test pattern generator.
//   vtg_mode_e : pattern select (SOLID, BARS, CHECKER, FILL)
//   BAR_TABLE  : colour-bar palette, entry 0 is the leftmost bar
// -----------------------------------------------------------------------------
package vtg_pkg;

   typedef enum logic [1:0] {
      SOLID   = 2'd0,
      BARS    = 2'd1,
      CHECKER = 2'd2,
      FILL    = 2'd3
   } vtg_mode_e;

   localparam int unsigned NUM_BARS = 8;

   localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
   localparam logic [23:0] RGB_BLACK = 24'h000000;

   // Packed so entry 0 (white) sits in the low bits; index with the bar number.
   localparam logic [NUM_BARS-1:0][23:0] BAR_TABLE = {
      24'h000000,  // 7 black
      24'h0000FF,  // 6 blue
      24'hFF0000,  // 5 red
      24'hFF00FF,  // 4 magenta
      24'h00FF00,  // 3 green
      24'h00FFFF,  // 2 cyan
      24'hFFFF00,  // 1 yellow
      24'hFFFFFF   // 0 white
   };

endpackage

// File: rtl/vtg_counter.sv
// -----------------------------------------------------------------------------
// vtg_counter
// Horizontal/vertical raster counters and the raw (unregistered) sync and
// data-enable decode. Line order is back porch, active, front porch, sync.
// Ports:
//   clk_pixel, rst_n : pixel clock, asynchronous active-low reset
//   en               : run enable; low holds both counters at 0
//   cnt_h, cnt_v     : raw raster position
//   hs, vs           : sync at its asserted polarity during the sync interval
//   de               : high inside the active window
// -----------------------------------------------------------------------------
module vtg_counter #(
   parameter int unsigned H_BPORCH = 40,
   parameter int unsigned H_ACTIVE = 2560,
   parameter int unsigned H_FPORCH = 8,
   parameter int unsigned H_SYNC   = 32,
   parameter int unsigned H_POLAR  = 1,
   parameter int unsigned V_BPORCH = 6,
   parameter int unsigned V_ACTIVE = 1440,
   parameter int unsigned V_FPORCH = 13,
   parameter int unsigned V_SYNC   = 8,
   parameter int unsigned V_POLAR  = 0,
   parameter int unsigned CNT_W    = 12
) (
   input  logic             clk_pixel,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt_h,
   output logic [CNT_W-1:0] cnt_v,
   output logic             hs,
   output logic             vs,
   output logic             de
);

   localparam int unsigned H_TOTAL = H_BPORCH + H_ACTIVE + H_FPORCH + H_SYNC;
   localparam int unsigned V_TOTAL = V_BPORCH + V_ACTIVE + V_FPORCH + V_SYNC;

   if ($clog2(H_TOTAL) > CNT_W) begin : g_h_width_err
      $error("vtg_counter: h_total %0d does not fit in CNT_W=%0d", H_TOTAL, CNT_W);
   end
   if ($clog2(V_TOTAL) > CNT_W) begin : g_v_width_err
      $error("vtg_counter: v_total %0d does not fit in CNT_W=%0d", V_TOTAL, CNT_W);
   end

   localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_DE_START   = CNT_W'(H_BPORCH);
   localparam logic [CNT_W-1:0] H_DE_END     = CNT_W'(H_BPORCH + H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_BPORCH + H_ACTIVE + H_FPORCH);
   localparam logic [CNT_W-1:0] V_DE_START   = CNT_W'(V_BPORCH);
   localparam logic [CNT_W-1:0] V_DE_END     = CNT_W'(V_BPORCH + V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_BPORCH + V_ACTIVE + V_FPORCH);
   localparam logic             HS_ON        = (H_POLAR != 0);
   localparam logic             VS_ON        = (V_POLAR != 0);

   logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
   logic [CNT_W-1:0] cnt_v_q, cnt_v_d;

   always_comb begin
      cnt_h_d = cnt_h_q;
      cnt_v_d = cnt_v_q;
      if (!en) begin
         cnt_h_d = '0;
         cnt_v_d = '0;
      end else if (cnt_h_q == H_LAST) begin
         cnt_h_d = '0;
         cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;
      end else begin
         cnt_h_d = cnt_h_q + 1'b1;
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         cnt_h_q <= '0;
         cnt_v_q <= '0;
      end else begin
         cnt_h_q <= cnt_h_d;
         cnt_v_q <= cnt_v_d;
      end
   end

   assign cnt_h = cnt_h_q;
   assign cnt_v = cnt_v_q;
   assign hs    = (cnt_h_q >= H_SYNC_START) ? HS_ON : ~HS_ON;
   assign vs    = (cnt_v_q >= V_SYNC_START) ? VS_ON : ~VS_ON;
   assign de    = (cnt_h_q >= H_DE_START) && (cnt_h_q < H_DE_END) &&
                  (cnt_v_q >= V_DE_START) && (cnt_v_q < V_DE_END);

endmodule

// File: rtl/vtg_pattern_gen.sv
// -----------------------------------------------------------------------------
// vtg_pattern_gen
// Video timing generator with built-in test patterns. Every output is
// registered one clock after the raster counters so all of them stay aligned.
// Ports:
//   clk_pixel, rst_n        : pixel clock, asynchronous active-low reset
//   en                      : run enable (PLL lock); low forces reset outputs
//   mode                    : pattern select, latched at the start of a frame
//   solid_rgb               : {R,G,B} colour for SOLID mode
//   rgb_hs, rgb_vs, rgb_de  : syncs and data enable
//   rgb_r, rgb_g, rgb_b     : pixel colour, 0 outside the active window
//   pos_x, pos_y            : active-area coordinates, 0 outside it
//   sof                     : one-cycle start-of-frame pulse
// -----------------------------------------------------------------------------
module vtg_pattern_gen
   import vtg_pkg::*;
#(
   parameter int unsigned H_BPORCH   = 40,
   parameter int unsigned H_ACTIVE   = 2560,
   parameter int unsigned H_FPORCH   = 8,
   parameter int unsigned H_SYNC     = 32,
   parameter int unsigned H_POLAR    = 1,
   parameter int unsigned V_BPORCH   = 6,
   parameter int unsigned V_ACTIVE   = 1440,
   parameter int unsigned V_FPORCH   = 13,
   parameter int unsigned V_SYNC     = 8,
   parameter int unsigned V_POLAR    = 0,
   parameter int unsigned CNT_W      = 12,
   parameter int unsigned CHECK_LOG2 = 5
) (
   input  logic             clk_pixel,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [23:0]      solid_rgb,
   output logic             rgb_hs,
   output logic             rgb_vs,
   output logic             rgb_de,
   output logic [7:0]       rgb_r,
   output logic [7:0]       rgb_g,
   output logic [7:0]       rgb_b,
   output logic [CNT_W-1:0] pos_x,
   output logic [CNT_W-1:0] pos_y,
   output logic             sof
);

   localparam int unsigned H_TOTAL = H_BPORCH + H_ACTIVE + H_FPORCH + H_SYNC;
   localparam int unsigned V_TOTAL = V_BPORCH + V_ACTIVE + V_FPORCH + V_SYNC;
   localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;

   if (CHECK_LOG2 >= CNT_W) begin : g_check_err
      $error("vtg_pattern_gen: CHECK_LOG2 %0d must be below CNT_W %0d", CHECK_LOG2, CNT_W);
   end

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [23:0]      FILL_MAX = 24'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic             HS_ON    = (H_POLAR != 0);
   localparam logic             VS_ON    = (V_POLAR != 0);

   logic [CNT_W-1:0] cnt_h, cnt_v;
   logic             hs_raw, vs_raw, de_raw;

   vtg_counter #(
      .H_BPORCH (H_BPORCH),
      .H_ACTIVE (H_ACTIVE),
      .H_FPORCH (H_FPORCH),
      .H_SYNC   (H_SYNC),
      .H_POLAR  (H_POLAR),
      .V_BPORCH (V_BPORCH),
      .V_ACTIVE (V_ACTIVE),
      .V_FPORCH (V_FPORCH),
      .V_SYNC   (V_SYNC),
      .V_POLAR  (V_POLAR),
      .CNT_W    (CNT_W)
   ) u_counter (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .en        (en),
      .cnt_h     (cnt_h),
      .cnt_v     (cnt_v),
      .hs        (hs_raw),
      .vs        (vs_raw),
      .de        (de_raw)
   );

   logic frame_start, frame_wrap;
   assign frame_start = en && (cnt_h == '0) && (cnt_v == '0);
   assign frame_wrap  = en && (cnt_h == H_LAST) && (cnt_v == V_LAST);

   logic [CNT_W-1:0] pos_x_c, pos_y_c;
   always_comb begin
      pos_x_c = '0;
      pos_y_c = '0;
      if (de_raw) begin
         pos_x_c = cnt_h - CNT_W'(H_BPORCH);
         pos_y_c = cnt_v - CNT_W'(V_BPORCH);
      end
   end

   // Bar index by comparison against constant boundaries; anything past the
   // last full bar lands on index 7 (black).
   logic [2:0] bar_idx;
   always_comb begin
      bar_idx = '0;
      for (int unsigned k = 1; k < NUM_BARS; k++) begin
         if (32'(pos_x_c) >= k * BAR_W) bar_idx = 3'(k);
      end
   end

   vtg_mode_e   mode_q, mode_d;
   logic [23:0] fill_idx_q, fill_idx_d;
   logic [23:0] fill_thr_q, fill_thr_d;

   always_comb begin
      mode_d     = frame_start ? vtg_mode_e'(mode) : mode_q;
      fill_idx_d = fill_idx_q;
      if (!en || (vs_raw == VS_ON)) fill_idx_d = '0;
      else if (de_raw)              fill_idx_d = fill_idx_q + 24'd1;
      // Advance as the raster wraps into the next frame's first pixel, so the
      // first frame after reset or enable shows threshold 0.
      fill_thr_d = fill_thr_q;
      if (frame_wrap) fill_thr_d = (fill_thr_q == FILL_MAX) ? '0 : fill_thr_q + 24'd1;
   end

   logic [23:0] pix_rgb;
   always_comb begin
      pix_rgb = RGB_BLACK;
      if (de_raw) begin
         case (mode_q)
            SOLID:   pix_rgb = solid_rgb;
            BARS:    pix_rgb = BAR_TABLE[bar_idx];
            CHECKER: pix_rgb = (pos_x_c[CHECK_LOG2] ^ pos_y_c[CHECK_LOG2]) ? RGB_BLACK
                                                                         : RGB_WHITE;
            FILL:    pix_rgb = (fill_idx_q < fill_thr_q) ? RGB_WHITE : RGB_BLACK;
            default: pix_rgb = RGB_BLACK;
         endcase
      end
   end

   logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
   logic [23:0]      rgb_q, rgb_d;
   logic [CNT_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;

   always_comb begin
      hs_d    = ~HS_ON;
      vs_d    = ~VS_ON;
      de_d    = 1'b0;
      sof_d   = 1'b0;
      rgb_d   = RGB_BLACK;
      pos_x_d = '0;
      pos_y_d = '0;
      if (en) begin
         hs_d    = hs_raw;
         vs_d    = vs_raw;
         de_d    = de_raw;
         sof_d   = frame_start;
         rgb_d   = pix_rgb;
         pos_x_d = pos_x_c;
         pos_y_d = pos_y_c;
      end
   end

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= SOLID;
         fill_idx_q <= '0;
         fill_thr_q <= '0;
         hs_q       <= ~HS_ON;
         vs_q       <= ~VS_ON;
         de_q       <= 1'b0;
         sof_q      <= 1'b0;
         rgb_q      <= RGB_BLACK;
         pos_x_q    <= '0;
         pos_y_q    <= '0;
      end else begin
         mode_q     <= mode_d;
         fill_idx_q <= fill_idx_d;
         fill_thr_q <= fill_thr_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         de_q       <= de_d;
         sof_q      <= sof_d;
         rgb_q      <= rgb_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
      end
   end

   assign rgb_hs = hs_q;
   assign rgb_vs = vs_q;
   assign rgb_de = de_q;
   assign sof    = sof_q;
   assign rgb_r  = rgb_q[23:16];
   assign rgb_g  = rgb_q[15:8];
   assign rgb_b  = rgb_q[7:0];
   assign pos_x  = pos_x_q;
   assign pos_y  = pos_y_q;

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// Directed bench for vtg_pattern_gen in a small raster:
// H 2/8/1/2 (13 clocks/line), V 1/4/1/1 (7 lines), 91 clocks/frame, 2x2 checker.
module tb_vtg_pattern_gen;

   localparam int unsigned CNT_W = 8;
   localparam int          FRAME = 91;
   localparam int          VW    = 4 + 2 * CNT_W + 24;

   logic             clk_pixel = 1'b0;
   logic             rst_n, en;
   logic [1:0]       mode;
   logic [23:0]      solid_rgb;
   logic             rgb_hs, rgb_vs, rgb_de, sof;
   logic [7:0]       rgb_r, rgb_g, rgb_b;
   logic [CNT_W-1:0] pos_x, pos_y;

   int n_checks = 0;
   int n_pass   = 0;
   int pos      = -1;  // raster position shown on the outputs, -1 = idle/reset
   int thr_m    = 0;   // fill threshold model
   int cur_mode = 0;   // mode in effect for the displayed frame

   vtg_pattern_gen #(
      .H_BPORCH (2), .H_ACTIVE (8), .H_FPORCH (1), .H_SYNC (2), .H_POLAR (1),
      .V_BPORCH (1), .V_ACTIVE (4), .V_FPORCH (1), .V_SYNC (1), .V_POLAR (0),
      .CNT_W (CNT_W), .CHECK_LOG2 (1)
   ) dut (
      .clk_pixel (clk_pixel),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .solid_rgb (solid_rgb),
      .rgb_hs    (rgb_hs),
      .rgb_vs    (rgb_vs),
      .rgb_de    (rgb_de),
      .rgb_r     (rgb_r),
      .rgb_g     (rgb_g),
      .rgb_b     (rgb_b),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .sof       (sof)
   );

   always #5 clk_pixel = ~clk_pixel;

   logic [VW-1:0] obs;
   assign obs = {rgb_hs, rgb_vs, rgb_de, sof, pos_x, pos_y, rgb_r, rgb_g, rgb_b};

   function automatic int h_of(int p);
      return p % 13;
   endfunction

   function automatic int v_of(int p);
      return p / 13;
   endfunction

   function automatic logic exp_de(int p);
      return (p >= 0) && (h_of(p) >= 2) && (h_of(p) <= 9) && (v_of(p) >= 1) && (v_of(p) <= 4);
   endfunction

   function automatic logic [23:0] bar_rgb(int x);
      case (x)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] exp_rgb(int p);
      int x, y;
      if (!exp_de(p)) return 24'h0;
      x = h_of(p) - 2;
      y = v_of(p) - 1;
      case (cur_mode)
         0:       return solid_rgb;
         1:       return bar_rgb(x);
         2:       return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
         default: return ((y * 8 + x) < thr_m) ? 24'hFFFFFF : 24'h000000;
      endcase
   endfunction

   // Expected {hs, vs, de, sof, pos_x, pos_y, rgb}; reset/idle: hs 0, vs 1.
   function automatic logic [VW-1:0] exp_vec(int p);
      logic             hs, vs, de, sf;
      logic [CNT_W-1:0] px, py;
      de = exp_de(p);
      hs = (p >= 0) && (h_of(p) >= 11);
      vs = !((p >= 0) && (v_of(p) == 6));
      sf = (p == 0);
      px = de ? CNT_W'(h_of(p) - 2) : '0;
      py = de ? CNT_W'(v_of(p) - 1) : '0;
      return {hs, vs, de, sf, px, py, exp_rgb(p)};
   endfunction

   // Advance one clock and the position model; inputs are driven 1 after edges.
   task automatic step();
      logic [1:0] m_pre;
      logic       en_pre;
      m_pre  = mode;
      en_pre = en;
      @(posedge clk_pixel);
      #1;
      if (!en_pre || !rst_n) pos = -1;
      else if (pos < 0) pos = 0;
      else begin
         pos++;
         if (pos == FRAME) begin
            pos   = 0;
            thr_m = (thr_m + 1) % 32;
         end
      end
      if (pos == 0) cur_mode = int'(m_pre);
   endtask

   task automatic apply_reset(input logic [1:0] m);
      rst_n    = 1'b0;
      en       = 1'b1;
      mode     = m;
      pos      = -1;
      thr_m    = 0;
      cur_mode = 0;
      repeat (3) @(posedge clk_pixel);
      #1;
   endtask

   task automatic test_reset();
      solid_rgb = 24'h123456;
      apply_reset(2'd0);
      n_checks++;
      if (obs !== exp_vec(-1)) $display("FAIL reset_state got=%h exp=%h", obs, exp_vec(-1));
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_timing();
      int sofs;
      sofs = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         if (sof === 1'b1) sofs++;
         n_checks++;
         if (obs !== exp_vec(pos)) $display("FAIL timing pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
         else n_pass++;
      end
      n_checks++;
      if (sofs !== 2) $display("FAIL sof_count got=%0d exp=2", sofs);
      else n_pass++;
   endtask

   task automatic test_mode_change();
      for (int i = 0; i < 32; i++) step();
      mode = 2'd1;  // mid-frame: solid must persist until the next sof
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(pos)) $display("FAIL bars pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
         else n_pass++;
      end
   endtask

   task automatic test_checker();
      mode = 2'd2;
      for (int i = 0; i < 2 * FRAME; i++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(pos)) $display("FAIL checker pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
         else n_pass++;
      end
   endtask

   task automatic test_fill();
      int whites;
      apply_reset(2'd3);
      rst_n = 1'b1;
      for (int f = 1; f <= 33; f++) begin
         whites = 0;
         for (int i = 0; i < FRAME; i++) begin
            step();
            if (rgb_de === 1'b1 && {rgb_r, rgb_g, rgb_b} === 24'hFFFFFF) whites++;
            n_checks++;
            if (obs !== exp_vec(pos)) $display("FAIL fill pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
            else n_pass++;
         end
         n_checks++;
         if (whites !== ((f <= 32) ? f - 1 : 0))
            $display("FAIL fill_count frame=%0d got=%0d exp=%0d", f, whites, (f <= 32) ? f - 1 : 0);
         else n_pass++;
      end
   endtask

   task automatic test_en_drop();
      solid_rgb = 24'hA5C3E1;
      apply_reset(2'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 31; i++) step();
      mode = 2'd1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(pos)) $display("FAIL en_pre pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
         else n_pass++;
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(-1)) $display("FAIL en_low got=%h exp=%h", obs, exp_vec(-1));
         else n_pass++;
      end
      en = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(pos)) $display("FAIL en_restart pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 46; i++) step();
      n_checks++;
      if (obs !== exp_vec(45)) $display("FAIL pre_reset got=%h exp=%h", obs, exp_vec(45));
      else n_pass++;
      #2;
      rst_n = 1'b0;  // between clock edges
      #1;
      n_checks++;
      if (obs !== exp_vec(-1)) $display("FAIL async_reset got=%h exp=%h", obs, exp_vec(-1));
      else n_pass++;
      pos      = -1;
      thr_m    = 0;
      cur_mode = 0;
      @(posedge clk_pixel);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         step();
         n_checks++;
         if (obs !== exp_vec(pos)) $display("FAIL reset_restart pos=%0d got=%h exp=%h", pos, obs, exp_vec(pos));
         else n_pass++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_timing();
      test_mode_change();
      test_checker();
      test_fill();
      test_en_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
